// File: rtl/adf4159_reg_seq.sv
// ADF4159 register sequencer: an 11-word shadow file that is streamed, one
// word per load/busy handshake, to the downstream SPI shifter.
module adf4159_reg_seq #(
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        init_start,
  input  logic        tune_start,
  input  logic        spi_busy,
  output logic        load,
  output logic [31:0] reg_var,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int NUM_SLOTS = 11;
  localparam int TO_W      = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_LEN   = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int GAP_W     = $clog2(GAP_LEN + 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(ACK_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  // Control bits [2:0] that each shadow slot always carries.
  function automatic logic [2:0] slot_ctrl(input logic [3:0] slot);
    logic [2:0] c;
    case (slot)
      4'd0:          c = 3'd7;
      4'd1, 4'd2:    c = 3'd6;
      4'd3, 4'd4:    c = 3'd5;
      4'd5, 4'd6:    c = 3'd4;
      4'd7:          c = 3'd3;
      4'd8:          c = 3'd2;
      4'd9:          c = 3'd1;
      default:       c = 3'd0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] force_ctrl(input logic [31:0] word, input logic [3:0] slot);
    return (word & 32'hFFFF_FFF8) | {29'd0, slot_ctrl(slot)};
  endfunction

  logic [31:0]      shadow_r [NUM_SLOTS];
  state_t           state_r, state_nxt;
  logic [3:0]       ptr_r, ptr_nxt;
  logic [3:0]       end_r, end_nxt;
  logic [TO_W-1:0]  to_cnt_r, to_cnt_nxt, to_inc;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_nxt;
  logic             load_nxt, busy_nxt, done_nxt, err_nxt;
  logic [31:0]      reg_var_nxt;

  // Shadow file: writable in any state, control bits forced per slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_r[i] <= {29'd0, slot_ctrl(4'(i))};
      end
    end else if (wr_en && (wr_addr < 4'd11)) begin
      shadow_r[wr_addr] <= force_ctrl(wr_data, wr_addr);
    end
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_nxt   = state_r;
    ptr_nxt     = ptr_r;
    end_nxt     = end_r;
    to_cnt_nxt  = to_cnt_r;
    gap_cnt_nxt = gap_cnt_r;
    load_nxt    = load;
    reg_var_nxt = reg_var;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_nxt     = err;
    to_inc      = (to_cnt_r == TO_LIMIT) ? TO_LIMIT : (to_cnt_r + TO_W'(1));

    case (state_r)
      S_IDLE: begin
        if (init_start) begin
          ptr_nxt   = 4'd0;
          end_nxt   = 4'd10;
          err_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = S_FETCH;
        end else if (tune_start) begin
          ptr_nxt   = 4'd9;
          end_nxt   = 4'd10;
          err_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        reg_var_nxt = shadow_r[ptr_r];
        state_nxt   = S_ISSUE;
      end
      S_ISSUE: begin
        load_nxt   = 1'b1;
        to_cnt_nxt = '0;
        state_nxt  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (spi_busy) begin
          load_nxt  = 1'b0;
          state_nxt = S_WAIT_DONE;
        end else begin
          to_cnt_nxt = to_inc;
          if (to_inc == TO_LIMIT) begin
            // Shifter never acknowledged: abandon the whole sequence.
            load_nxt  = 1'b0;
            err_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!spi_busy) begin
          gap_cnt_nxt = '0;
          state_nxt   = S_GAP;
        end else begin
          state_nxt = S_WAIT_DONE;
        end
      end
      S_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          if (ptr_r == end_r) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            ptr_nxt   = ptr_r + 4'd1;
            state_nxt = S_FETCH;
          end
        end else begin
          gap_cnt_nxt = gap_cnt_r + GAP_W'(1);
          state_nxt   = S_GAP;
        end
      end
      default: begin
        load_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      ptr_r     <= 4'd0;
      end_r     <= 4'd0;
      to_cnt_r  <= '0;
      gap_cnt_r <= '0;
      load      <= 1'b0;
      reg_var   <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      ptr_r     <= ptr_nxt;
      end_r     <= end_nxt;
      to_cnt_r  <= to_cnt_nxt;
      gap_cnt_r <= gap_cnt_nxt;
      load      <= load_nxt;
      reg_var   <= reg_var_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_adf4159_reg_seq.sv
// Randomised bench for adf4159_reg_seq: a latency-level reference model of
// the sequencer plus a behavioural SPI shifter, compared on every falling edge.
`timescale 1ns/1ps
module tb_adf4159_reg_seq;
  localparam int GAP  = 4;
  localparam int TMO  = 64;
  localparam int GAPM = (GAP > 0) ? GAP : 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [31:0] wr_data = 32'd0;
  logic        init_start = 1'b0;
  logic        tune_start = 1'b0;
  logic        spi_busy;
  logic        load, busy, done, err;
  logic [31:0] reg_var;

  adf4159_reg_seq #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_start(init_start), .tune_start(tune_start), .spi_busy(spi_busy),
    .load(load), .reg_var(reg_var), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Control bits derived from the register number each slot programs.
  function automatic logic [2:0] ctl(input int s);
    if (s == 0) return 3'd7;
    else if (s <= 6) return 3'(7 - (s + 1) / 2);
    else return 3'(10 - s);
  endfunction

  // ---------------- shifter model ----------------
  int ack_dly = 3, busy_len = 70;
  bit no_ack = 1'b0;
  int sh_phase = 0, sh_cnt = 0;
  initial begin
    spi_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (sh_phase)
        0: if (load && !no_ack) begin sh_cnt = 1; sh_phase = 1; end
        1: if (sh_cnt >= ack_dly) begin spi_busy = 1'b1; sh_cnt = 1; sh_phase = 2; end
           else sh_cnt++;
        default: if (sh_cnt >= busy_len) begin spi_busy = 1'b0; sh_phase = 0; end
                 else sh_cnt++;
      endcase
    end
  end

  // ---------------- reference model (event times in falling edges) ----------------
  logic [31:0] m_shadow [11];
  logic        m_load, m_busy, m_done, m_err;
  logic [31:0] m_reg_var, fetched;
  bit          m_active, end_err;
  int          cyc = 0;
  int          t_busy, t_fetch, t_load, t_unload, t_end, ack_from, fall_from, cur_slot;
  int          slots[$];

  task automatic model_reset();
    for (int i = 0; i < 11; i++) m_shadow[i] = {29'd0, ctl(i)};
    m_load = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_reg_var = 32'd0;
    m_active = 1'b0; end_err = 1'b0; fetched = 32'd0; cur_slot = 0;
    t_busy = -1; t_fetch = -1; t_load = -1; t_unload = -1; t_end = -1;
    ack_from = -1; fall_from = -1;
    slots.delete();
  endtask

  // observation bookkeeping
  logic [31:0] frame_log[$];
  int  done_cnt = 0, load_run = 0, last_run = 0, last_fall = -1, min_gap = 1000000;
  logic prev_load = 1'b0, prev_spi = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    m_done = 1'b0;
    if (cyc == t_busy) begin m_busy = 1'b1; m_err = 1'b0; end
    if (cyc == t_fetch) m_reg_var = fetched;
    if (cyc == t_load) begin m_load = 1'b1; ack_from = cyc; end
    if (cyc == t_unload) m_load = 1'b0;
    if (cyc == t_end) begin
      m_busy = 1'b0; m_active = 1'b0; slots.delete();
      if (end_err) begin m_err = 1'b1; m_load = 1'b0; end
      else m_done = 1'b1;
    end

    chk("load",    {31'd0, load}, {31'd0, m_load});
    chk("busy",    {31'd0, busy}, {31'd0, m_busy});
    chk("done",    {31'd0, done}, {31'd0, m_done});
    chk("err",     {31'd0, err},  {31'd0, m_err});
    chk("reg_var", reg_var, m_reg_var);

    // react to inputs seen now; they are sampled at the next rising edge
    if (m_active && ack_from >= 0) begin
      if (spi_busy) begin
        t_unload = cyc + 1; fall_from = cyc + 1; ack_from = -1;
      end else if (cyc - ack_from + 1 == TMO) begin
        t_end = cyc + 1; end_err = 1'b1; ack_from = -1;
      end
    end else if (m_active && fall_from >= 0 && cyc >= fall_from && !spi_busy) begin
      fall_from = -1;
      if (slots.size() == 0) begin
        t_end = cyc + GAPM + 1; end_err = 1'b0;
      end else begin
        cur_slot = slots.pop_front();
        t_fetch = cyc + GAPM + 2; t_load = cyc + GAPM + 3;
      end
    end
    if (!m_active && (init_start || tune_start)) begin
      slots.delete();
      for (int s = (init_start ? 0 : 9); s < 11; s++) slots.push_back(s);
      cur_slot = slots.pop_front();
      m_active = 1'b1;
      t_busy = cyc + 1; t_fetch = cyc + 2; t_load = cyc + 3;
    end
    if (cyc + 1 == t_fetch) fetched = m_shadow[cur_slot];
    if (wr_en && wr_addr < 4'd11) m_shadow[wr_addr] = {wr_data[31:3], ctl(int'(wr_addr))};

    if (load && !prev_load) begin
      frame_log.push_back(reg_var);
      if (last_fall >= 0 && cyc - last_fall < min_gap) min_gap = cyc - last_fall;
    end
    if (load) load_run++;
    else if (prev_load) begin last_run = load_run; load_run = 0; end
    if (prev_spi && !spi_busy) last_fall = cyc;
    if (done) done_cnt++;
    prev_load = load;
    prev_spi  = spi_busy;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit i, input bit t);
    init_start = i; tune_start = t;
    tick();
    init_start = 1'b0; tune_start = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((m_active || busy) && n < budget) begin tick(); n++; end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_obs();
    frame_log.delete(); done_cnt = 0; min_gap = 1000000;
  endtask

  int exp_ctrl[11] = '{7, 6, 6, 5, 5, 4, 4, 3, 2, 1, 0};

  task automatic check_order(input string name);
    chk({name, "_count"}, frame_log.size(), 32'd11);
    for (int i = 0; i < 11 && i < frame_log.size(); i++)
      chk(name, {29'd0, frame_log[i][2:0]}, exp_ctrl[i]);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();
    repeat (3) tick();
    chk("rst_load", {31'd0, load}, 32'd0);
    chk("rst_reg_var", reg_var, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    tick();

    // full initialisation, 3-cycle ack / 70-cycle frames
    clear_obs();
    pulse_start(1'b1, 1'b0);
    chk("init_busy_after_start", {31'd0, busy}, 32'd1);
    wait_idle("init_finish", 1500);
    check_order("init_order");
    chk("init_done_cnt", done_cnt, 32'd1);
    chk("init_err", {31'd0, err}, 32'd0);

    // retune with slot 10 all ones
    wr(4'd10, 32'hFFFF_FFFF);
    clear_obs();
    pulse_start(1'b0, 1'b1);
    wait_idle("tune_finish", 500);
    chk("tune_count", frame_log.size(), 32'd2);
    if (frame_log.size() == 2) begin
      chk("tune_r1", frame_log[0], 32'h0000_0001);
      chk("tune_r0", frame_log[1], 32'hFFFF_FFF8);
    end
    chk("tune_gap_ok", {31'd0, min_gap >= GAP + 1}, 32'd1);
    chk("tune_done_cnt", done_cnt, 32'd1);

    // simultaneous starts, then a dropped retune mid-sequence
    clear_obs();
    pulse_start(1'b1, 1'b1);
    repeat (200) tick();
    pulse_start(1'b0, 1'b1);
    wait_idle("both_finish", 1500);
    check_order("both_order");
    chk("both_done_cnt", done_cnt, 32'd1);

    // shifter never acknowledges
    no_ack = 1'b1;
    clear_obs();
    pulse_start(1'b1, 1'b0);
    wait_idle("to_finish", 300);
    chk("to_load_len", last_run, TMO);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_done_cnt", done_cnt, 32'd0);
    no_ack = 1'b0;
    clear_obs();
    pulse_start(1'b1, 1'b0);
    chk("to_err_cleared", {31'd0, err}, 32'd0);
    wait_idle("to_recover", 1500);
    check_order("to_recover_order");
    chk("to_recover_done", done_cnt, 32'd1);

    // asynchronous reset while slot 5 is being shifted
    clear_obs();
    pulse_start(1'b1, 1'b0);
    n = 0;
    while (frame_log.size() < 6 && n < 1000) begin tick(); n++; end
    while (load && n < 1000) begin tick(); n++; end
    chk("rst_reach_slot5", frame_log.size(), 32'd6);
    tick();
    @(negedge clk); #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_load", {31'd0, load}, 32'd0);
    chk("arst_reg_var", reg_var, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    n = 0;
    while (spi_busy && n < 200) begin @(negedge clk); n++; end
    chk("arst_shifter_idle", {31'd0, spi_busy}, 32'd0);
    tick();
    clear_obs();
    pulse_start(1'b1, 1'b0);
    wait_idle("arst_restart", 1500);
    check_order("arst_order");

    // ignored out-of-range write and forced control bits
    wr(4'd12, 32'hDEAD_BEEF);
    wr(4'd3, 32'hABCD_1230);
    clear_obs();
    pulse_start(1'b1, 1'b0);
    wait_idle("wr_finish", 1500);
    if (frame_log.size() == 11) begin
      chk("wr_slot3", frame_log[3], 32'hABCD_1235);
      chk("wr_slot4_untouched", frame_log[4], 32'h0000_0005);
      chk("wr_slot10_untouched", frame_log[10], 32'h0000_0000);
    end else begin
      chk("wr_count", frame_log.size(), 32'd11);
    end

    // randomised sequences with writes and stray starts throughout
    for (int r = 0; r < 25; r++) begin
      int sel;
      ack_dly  = $urandom_range(1, 5);
      busy_len = $urandom_range(1, 12);
      no_ack   = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 2);
      init_start = (sel != 1);
      tune_start = (sel != 0);
      tick();
      init_start = 1'b0; tune_start = 1'b0;
      n = 0;
      while ((m_active || busy) && n < 1500) begin
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_addr = 4'($urandom_range(0, 15));
        wr_data = $urandom;
        if ($urandom_range(0, 19) == 0) tune_start = 1'b1;
        if ($urandom_range(0, 29) == 0) init_start = 1'b1;
        tick();
        wr_en = 1'b0; init_start = 1'b0; tune_start = 1'b0;
        n++;
      end
      chk("rand_idle", {31'd0, busy}, 32'd0);
    end
    no_ack = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
